// File: rtl/eBike_pkg.sv
// Shared eBike definitions: telemetry FSM states, frame geometry and period widths.
// Also holds small helpers for splitting 12-bit readings into frame bytes.
package eBike_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} tele_state_t;

    localparam int FRAME_LEN     = 8;
    localparam int IDX_W         = $clog2(FRAME_LEN);
    localparam int PERIOD_W_FAST = 12;
    localparam int PERIOD_W_FULL = 22;

    // Upper byte of a reading carries only its top nibble; the rest is zero.
    function automatic logic [7:0] reading_hi(input logic [11:0] r);
        return {4'h0, r[11:8]};
    endfunction

    function automatic logic [7:0] reading_lo(input logic [11:0] r);
        return r[7:0];
    endfunction

endpackage

// File: rtl/tele_period_timer.sv
// Free-running wrap-around counter; tick pulses for one clock while the count is all-ones.
// Runs regardless of any enable so the period stays phase-locked to reset.
module tele_period_timer #(
    parameter int unsigned WIDTH = 12
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign tick = &count;

endmodule

// File: rtl/telemetry_sched.sv
// Periodic telemetry framer: snapshots batt/curr/torque on each period tick and
// feeds an 8-byte frame (2 header bytes + three 12-bit readings) to UART_tx.
module telemetry_sched
    import eBike_pkg::*;
#(
    parameter int         FAST_SIM = 1,
    parameter logic [7:0] HDR0     = 8'hAA,
    parameter logic [7:0] HDR1     = 8'h55
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] batt,
    input  logic [11:0] curr,
    input  logic [11:0] torque,
    input  logic        tx_done,
    output logic        trmt,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam int PERIOD_W = (FAST_SIM != 0) ? PERIOD_W_FAST : PERIOD_W_FULL;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    tele_state_t      state;
    logic             tick;
    logic [IDX_W-1:0] idx;
    logic [11:0]      snap_batt;
    logic [11:0]      snap_curr;
    logic [11:0]      snap_torque;
    logic [7:0]       frame_byte;

    tele_period_timer #(
        .WIDTH(PERIOD_W)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Frame bytes come only from the snapshot, never from the live inputs.
    always_comb begin
        frame_byte = '0;
        case (idx)
            3'd0:    frame_byte = HDR0;
            3'd1:    frame_byte = HDR1;
            3'd2:    frame_byte = reading_hi(snap_batt);
            3'd3:    frame_byte = reading_lo(snap_batt);
            3'd4:    frame_byte = reading_hi(snap_curr);
            3'd5:    frame_byte = reading_lo(snap_curr);
            3'd6:    frame_byte = reading_hi(snap_torque);
            3'd7:    frame_byte = reading_lo(snap_torque);
            default: frame_byte = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            snap_batt   <= '0;
            snap_curr   <= '0;
            snap_torque <= '0;
            trmt        <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            trmt       <= 1'b0;
            frame_done <= 1'b0;

            // A tick that finds a frame still in flight is dropped, not queued.
            if (tick && en && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (tick && en) begin
                        snap_batt   <= batt;
                        snap_curr   <= curr;
                        snap_torque <= torque;
                        idx         <= '0;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    tx_data <= frame_byte;
                    trmt    <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        if (idx == LAST_IDX) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= LOAD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_sched.sv
// Self-checking bench for telemetry_sched: event-timed reference model checked every
// cycle, a UART responder with configurable delay, and literal frame expectations.
module tb_telemetry_sched;

    localparam int PERIOD = 4096;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        en      = 1'b1;
    logic [11:0] batt    = 12'hABC;
    logic [11:0] curr    = 12'h123;
    logic [11:0] torque  = 12'h7FF;
    logic        tx_done = 1'b0;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    always #5 clk = ~clk;

    telemetry_sched #(
        .FAST_SIM(1),
        .HDR0    (8'hAA),
        .HDR1    (8'h55)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .batt      (batt),
        .curr      (curr),
        .torque    (torque),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .busy      (busy),
        .frame_done(frame_done),
        .overrun   (overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic logic [63:0] exp_frame(input logic [11:0] b, input logic [11:0] c,
                                              input logic [11:0] t);
        return {8'hAA, 8'h55, 8'(b / 256), 8'(b % 256), 8'(c / 256), 8'(c % 256),
                8'(t / 256), 8'(t % 256)};
    endfunction

    // UART responder: tx_done uart_delay cycles after each trmt, plus optional spurious pulses.
    int         uart_delay = 10;
    bit         spur_mode  = 1'b0;
    int         trmt_count = 0;
    int         ncyc       = 0;
    int         due        = -1;
    logic [7:0] cap[$];

    always @(negedge clk) begin
        ncyc++;
        tx_done = 1'b0;
        if (rst) begin
            due = -1;
        end else if (trmt) begin
            cap.push_back(tx_data);
            trmt_count++;
            due = ncyc + uart_delay;
            if (spur_mode) tx_done = 1'b1;
        end else if (ncyc == due) begin
            tx_done = 1'b1;
        end else if (spur_mode && !busy && (ncyc % 37 == 0)) begin
            tx_done = 1'b1;
        end
    end

    // Reference model: timeline of frame events counted in clock edges since reset release.
    int         ecount          = 0;
    int         m_cnt           = 0;
    int         m_idx           = 0;
    int         trmt_edge       = -10;
    int         done_edge       = -1;
    bit         m_busy          = 1'b0;
    bit         m_ovr           = 1'b0;
    bit         m_tick;
    bit         m_started;
    logic [7:0] m_data          = 8'h00;
    logic [7:0] m_bytes[8];
    int         fd_count        = 0;
    int         first_trmt_edge = -1;

    always @(posedge clk) begin
        if (rst) begin
            ecount    = 0;
            m_cnt     = 0;
            m_busy    = 1'b0;
            m_ovr     = 1'b0;
            m_data    = 8'h00;
            trmt_edge = -10;
            done_edge = -1;
        end else begin
            ecount++;
            m_tick    = (m_cnt == PERIOD - 1);
            m_cnt     = (m_cnt + 1) % PERIOD;
            m_started = 1'b0;
            if (m_tick && en) begin
                if (m_busy) begin
                    m_ovr = 1'b1;
                end else begin
                    m_busy     = 1'b1;
                    m_started  = 1'b1;
                    m_idx      = 0;
                    m_bytes[0] = 8'hAA;
                    m_bytes[1] = 8'h55;
                    m_bytes[2] = 8'(batt / 256);
                    m_bytes[3] = 8'(batt % 256);
                    m_bytes[4] = 8'(curr / 256);
                    m_bytes[5] = 8'(curr % 256);
                    m_bytes[6] = 8'(torque / 256);
                    m_bytes[7] = 8'(torque % 256);
                    trmt_edge  = ecount + 1;
                end
            end
            // tx_done only counts once the byte's trmt cycle is over.
            if (!m_started && m_busy && tx_done && ecount >= trmt_edge + 2) begin
                if (m_idx == 7) begin
                    m_busy    = 1'b0;
                    done_edge = ecount;
                end else begin
                    m_idx++;
                    trmt_edge = ecount + 1;
                end
            end
            if (m_busy && ecount == trmt_edge) m_data = m_bytes[m_idx];
        end
        #1;
        check("outputs{trmt,busy,frame_done,overrun,tx_data}",
              {trmt, busy, frame_done, overrun, tx_data},
              {m_busy && (ecount == trmt_edge), m_busy, ecount == done_edge, m_ovr, m_data});
        if (!rst && frame_done) fd_count++;
        if (!rst && trmt && first_trmt_edge < 0) first_trmt_edge = ecount;
    end

    task automatic wait_trmts(input int target, input int budget, input string name);
        int n = 0;
        while (trmt_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (trmt_count < target) check(name, trmt_count, target);
    endtask

    task automatic wait_fd(input int target, input int budget, input string name, input bit jit);
        int n = 0;
        while (fd_count < target && n < budget) begin
            @(negedge clk);
            if (jit && busy) begin
                batt   = 12'($urandom);
                curr   = 12'($urandom);
                torque = 12'($urandom);
            end
            n++;
        end
        if (fd_count < target) check(name, fd_count, target);
    endtask

    task automatic check_frame(input string name, input logic [63:0] exp);
        logic [63:0] got = '0;
        check({name, "_len"}, cap.size(), 8);
        if (cap.size() == 8)
            got = {cap[0], cap[1], cap[2], cap[3], cap[4], cap[5], cap[6], cap[7]};
        check(name, got, exp);
    endtask

    initial begin
        int          base;
        int          fdb;
        logic [11:0] rb;
        logic [11:0] rc;
        logic [11:0] rt;

        repeat (3) @(negedge clk);
        check("reset_outputs", {trmt, busy, frame_done, overrun, tx_data}, 12'h000);
        #3 rst = 1'b0;

        // Frame 1 with batt changed after byte 2 goes out; frame 2 then carries batt=000.
        cap.delete();
        wait_trmts(3, 6000, "t1_byte2_timeout");
        batt = 12'h000;
        wait_fd(1, 6000, "t1_frame_timeout", 1'b0);
        check_frame("t1_frame", 64'hAA55_0ABC_0123_07FF);
        check("t1_trmt_count", trmt_count, 8);
        check("t1_frame_done_count", fd_count, 1);
        check("t1_first_trmt_edge", first_trmt_edge, PERIOD + 1);
        @(negedge clk);
        check("t1_busy_after", busy, 0);
        cap.delete();
        wait_fd(2, 6000, "t2_frame_timeout", 1'b0);
        check_frame("t2_frame", 64'hAA55_0000_0123_07FF);

        // Enable low across two ticks, then en drops during byte 4 of the next frame.
        en = 1'b0;
        repeat (2 * PERIOD + 100) @(negedge clk);
        check("t4_no_trmt", trmt_count, 16);
        check("t4_busy", busy, 0);
        check("t4_overrun", overrun, 0);
        rb = 12'($urandom); rc = 12'($urandom); rt = 12'($urandom);
        batt = rb; curr = rc; torque = rt;
        en = 1'b1;
        cap.delete();
        base = trmt_count;
        wait_trmts(base + 5, 6000, "t4_byte4_timeout");
        en = 1'b0;
        wait_fd(3, 6000, "t4_frame_timeout", 1'b0);
        repeat (PERIOD + 50) @(negedge clk);
        check_frame("t4_frame", exp_frame(rb, rc, rt));
        check("t4_trmt_count", trmt_count, base + 8);
        check("t4_frame_done_count", fd_count, 3);

        // Slow UART: frame spans ticks, overrun sets, inputs jitter during the frame.
        rb = 12'($urandom); rc = 12'($urandom); rt = 12'($urandom);
        batt = rb; curr = rc; torque = rt;
        uart_delay = 1500;
        en = 1'b1;
        cap.delete();
        base = trmt_count;
        check("t3_overrun_before", overrun, 0);
        wait_fd(4, 20000, "t3_frame_timeout", 1'b1);
        check_frame("t3_frame", exp_frame(rb, rc, rt));
        check("t3_overrun_after", overrun, 1);
        check("t3_trmt_count", trmt_count, base + 8);
        uart_delay = 10;

        // Reset during WAIT of byte 5, then a full frame after release.
        rb = 12'($urandom); rc = 12'($urandom); rt = 12'($urandom);
        batt = rb; curr = rc; torque = rt;
        base = trmt_count;
        wait_trmts(base + 6, 6000, "t5_byte5_timeout");
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        #1 check("t5_reset_outputs", {trmt, busy, frame_done, overrun, tx_data}, 12'h000);
        repeat (2) @(negedge clk);
        rb = 12'($urandom); rc = 12'($urandom); rt = 12'($urandom);
        batt = rb; curr = rc; torque = rt;
        cap.delete();
        fdb = fd_count;
        #3 rst = 1'b0;
        wait_fd(fdb + 1, 6000, "t5_frame_timeout", 1'b0);
        check_frame("t5_frame", exp_frame(rb, rc, rt));
        check("t5_overrun_cleared", overrun, 0);

        // Spurious tx_done pulses in IDLE and alongside trmt.
        rb = 12'($urandom); rc = 12'($urandom); rt = 12'($urandom);
        batt = rb; curr = rc; torque = rt;
        spur_mode = 1'b1;
        cap.delete();
        base = trmt_count;
        fdb = fd_count;
        wait_fd(fdb + 1, 6000, "t6_frame_timeout", 1'b0);
        check_frame("t6_frame", exp_frame(rb, rc, rt));
        check("t6_trmt_count", trmt_count, base + 8);
        spur_mode = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
